// File: rtl/ahfp_pkg.sv
// ahfp_pkg: shared single-precision constants and helpers for the ahfp blocks.
//   AHFP_W / AHFP_EXP_W / AHFP_MAN_W : IEEE-754 single field widths
//   AHFP_ZERO, AHFP_QNAN            : canonical +0 and quiet NaN
//   ahfp_clz27()                    : leading-zero count of the adder's 27-bit
//                                     working significand (27 when all zero)
package ahfp_pkg;
  localparam int AHFP_W     = 32;
  localparam int AHFP_EXP_W = 8;
  localparam int AHFP_MAN_W = 23;

  localparam logic [AHFP_W-1:0] AHFP_ZERO = 32'h0000_0000;
  localparam logic [AHFP_W-1:0] AHFP_QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] ahfp_clz27(input logic [26:0] v);
    logic [4:0] n;
    logic       hit;
    n   = 5'd27;
    hit = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!hit && v[i]) begin
        n   = 5'(26 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction
endpackage

// File: rtl/ahfp_add.sv
// ahfp_add: combinational IEEE-754 single-precision adder, round-to-nearest-even.
//   dataa, datab : operands
//   result       : dataa + datab
// Denormals are handled in full; any NaN input gives the canonical quiet NaN,
// inf + -inf gives quiet NaN, overflow rounds to a signed infinity, and an
// exact cancellation gives +0.
module ahfp_add
  import ahfp_pkg::*;
(
  input  logic [AHFP_W-1:0] dataa,
  input  logic [AHFP_W-1:0] datab,
  output logic [AHFP_W-1:0] result
);
  logic        swap, sub, a_nan, b_nan, a_inf, b_inf, rsign, rnd, stk;
  logic [31:0] big, sml;
  logic [7:0]  xb, xs, d, sh, lz8;
  logic [23:0] mb, ms;
  logic [26:0] mb_x, ms_x, ms_sh, align, norm;
  logic [27:0] sum;
  logic [24:0] m25;
  logic [9:0]  e;
  logic [22:0] frac;
  logic [4:0]  lz;

  assign a_nan = (&dataa[30:23]) && (|dataa[22:0]);
  assign b_nan = (&datab[30:23]) && (|datab[22:0]);
  assign a_inf = (&dataa[30:23]) && !(|dataa[22:0]);
  assign b_inf = (&datab[30:23]) && !(|datab[22:0]);

  // Order by magnitude so the subtraction below never goes negative.
  assign swap = datab[30:0] > dataa[30:0];
  assign big  = swap ? datab : dataa;
  assign sml  = swap ? dataa : datab;
  // Denormals use an effective exponent of 1 with no hidden bit.
  assign xb   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
  assign xs   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
  assign mb   = {|big[30:23], big[22:0]};
  assign ms   = {|sml[30:23], sml[22:0]};
  assign d    = xb - xs;
  assign sub  = big[31] ^ sml[31];
  assign mb_x = {mb, 3'b000};
  assign ms_x = {ms, 3'b000};

  // Align the smaller operand; bits shifted out collapse into the sticky bit.
  always_comb begin
    ms_sh = '0;
    stk   = 1'b0;
    if (d >= 8'd27) begin
      stk = |ms;
    end else begin
      ms_sh = ms_x >> d;
      stk   = |(ms_x & ~({27{1'b1}} << d));
    end
  end
  assign align = {ms_sh[26:1], ms_sh[0] | stk};
  assign sum   = sub ? ({1'b0, mb_x} - {1'b0, align}) : ({1'b0, mb_x} + {1'b0, align});
  assign lz    = ahfp_clz27(sum[26:0]);
  assign lz8   = {3'b000, lz};

  always_comb begin
    norm = '0;
    e    = '0;
    sh   = '0;
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = {2'b00, xb} + 10'd1;
    end else begin
      // Never shift below the minimum exponent: that lands in denormal range.
      sh   = (lz8 < xb - 8'd1) ? lz8 : (xb - 8'd1);
      norm = sum[26:0] << sh;
      e    = norm[26] ? {2'b00, xb - sh} : 10'd0;
    end
    rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
    m25  = {1'b0, norm[26:3]} + {24'd0, rnd};
    frac = m25[22:0];
    if (m25[24]) begin
      e    = e + 10'd1;
      frac = '0;
    end else if (e == 10'd0 && m25[23]) begin
      e = 10'd1;  // denormal rounded up into the smallest normal
    end
  end

  assign rsign = (sub && sum == 28'd0) ? 1'b0 : big[31];

  always_comb begin
    if (a_nan || b_nan || (a_inf && b_inf && sub)) result = AHFP_QNAN;
    else if (a_inf)                                 result = dataa;
    else if (b_inf)                                 result = datab;
    else if (e >= 10'd255)                          result = {rsign, 8'hFF, 23'd0};
    else                                            result = {rsign, e[7:0], frac};
  end
endmodule

// File: rtl/ahfp_rr_pick.sv
// ahfp_rr_pick: combinational round-robin picker.
//   req    : request vector
//   last   : index of the most recent grant; search starts at last+1
//   en     : grant enable; no grant when low
//   gnt    : one-hot grant
//   gnt_id : index of the granted requester
//   any    : a grant is being issued
module ahfp_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (en && !any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahfp_add_arb.sv
// ahfp_add_arb: round-robin arbiter sharing one ahfp_add among N requesters.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake; req_ready is a one-hot grant
//   req_dataa/req_datab   : packed operand pairs, requester i at [32i+31:32i]
//   res_valid/res_ready   : registered result handshake
//   res_data, res_id      : sum and index of the requester that produced it
// Build option AHFP_ARB_IN_REG_EN: adds an operand register stage in front of
// the adder (2-cycle latency instead of 1); ordering and fairness are unchanged.
module ahfp_add_arb
  import ahfp_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [AHFP_W*N-1:0] req_dataa,
  input  logic [AHFP_W*N-1:0] req_datab,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [AHFP_W-1:0]   res_data,
  output logic [IDW-1:0]      res_id
);
  logic [N-1:0][AHFP_W-1:0] opa, opb;
  logic [N-1:0]             gnt;
  logic [IDW-1:0]           gnt_id, last, out_id;
  logic                     any, pick_en, adv, out_v;
  logic [AHFP_W-1:0]        add_a, add_b, sum;

  assign opa       = req_dataa;
  assign opb       = req_datab;
  // Output slot is empty or drains on this edge.
  assign adv       = !res_valid || res_ready;
  assign req_ready = gnt;

  ahfp_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req_valid),
    .last   (last),
    .en     (pick_en),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

`ifdef AHFP_ARB_IN_REG_EN
  logic              s1_valid, s1_adv;
  logic [AHFP_W-1:0] s1_a, s1_b;
  logic [IDW-1:0]    s1_id;

  assign s1_adv  = !s1_valid || adv;
  assign pick_en = s1_adv && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= AHFP_ZERO;
      s1_b     <= AHFP_ZERO;
      s1_id    <= '0;
    end else if (s1_adv) begin
      s1_valid <= any;
      if (any) begin
        s1_a  <= opa[gnt_id];
        s1_b  <= opb[gnt_id];
        s1_id <= gnt_id;
      end
    end
  end

  assign add_a  = s1_a;
  assign add_b  = s1_b;
  assign out_v  = s1_valid;
  assign out_id = s1_id;
`else
  assign pick_en = adv && !reset;
  assign add_a   = opa[gnt_id];
  assign add_b   = opb[gnt_id];
  assign out_v   = any;
  assign out_id  = gnt_id;
`endif

  ahfp_add u_add (
    .dataa  (add_a),
    .datab  (add_b),
    .result (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= AHFP_ZERO;
      res_id    <= '0;
      last      <= IDW'(N - 1);
    end else begin
      if (any) last <= gnt_id;
      // An idle advance empties the slot; data/id are kept but not valid.
      if (adv) begin
        res_valid <= out_v;
        if (out_v) begin
          res_data <= sum;
          res_id   <= out_id;
        end
      end
    end
  end
endmodule
